// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a registered result.
// Shifts either finish in one cycle or walk one bit per cycle, depending on FAST_SHIFT.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter bit FAST_SHIFT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  count_q, count_d;
    logic [3:0]      sel_q, sel_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] op_res;
    logic            op_illegal;
    logic            is_shift;
    logic [XLEN-1:0] work_step;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        op_res     = '0;
        op_illegal = 1'b0;
        case (alu_sel)
            SEL_AND:  op_res = op_a & op_b;
            SEL_OR:   op_res = op_a | op_b;
            SEL_ADD:  op_res = op_a + op_b;
            SEL_SUB:  op_res = op_a - op_b;
            SEL_XOR:  op_res = op_a ^ op_b;
            SEL_SLL:  op_res = op_a << shamt;
            SEL_SRL:  op_res = op_a >> shamt;
            SEL_SRA:  op_res = $unsigned($signed(op_a) >>> shamt);
            SEL_SLT:  op_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            SEL_SLTU: op_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  op_illegal = 1'b1;
        endcase
    end

    assign is_shift = (alu_sel == SEL_SLL) || (alu_sel == SEL_SRL) || (alu_sel == SEL_SRA);

    // One-bit step of the iterative shifter; sel_q only ever holds a shift code here.
    always_comb begin
        case (sel_q)
            SEL_SLL: work_step = {work_q[XLEN-2:0], 1'b0};
            SEL_SRL: work_step = {1'b0, work_q[XLEN-1:1]};
            default: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        work_d    = work_q;
        count_d   = count_q;
        sel_d     = sel_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && !FAST_SHIFT && (shamt != '0)) begin
                        work_d  = op_a;
                        count_d = shamt;
                        sel_d   = alu_sel;
                        state_d = SHIFT;
                    end else begin
                        result_d  = op_res;
                        zero_d    = (op_res == '0);
                        illegal_d = op_illegal;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d  = work_step;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    result_d  = work_step;
                    zero_d    = (work_step == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            count_q   <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, iterative shifter): vector table plus
// hand-written reset-mid-shift and back-pressure sequences.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(.XLEN(32), .FAST_SHIFT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [3:0] sel, logic [31:0] a, logic [31:0] b,
                                logic [31:0] exp_res, logic exp_zero, logic exp_ill, int exp_lat);
        vec_t v;
        v.name = name; v.sel = sel; v.a = a; v.b = b;
        v.exp_res = exp_res; v.exp_zero = exp_zero; v.exp_ill = exp_ill; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Presents a request and holds it across one edge; afterwards the inputs are scrambled.
    task automatic apply_stimulus(input string name, input logic [3:0] sel,
                                  input logic [31:0] a, input logic [31:0] b);
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        check_output({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_sel  = 4'b0010;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Cycle index (1 = cycle after accept edge) at which out_valid is first seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int lat;
        apply_stimulus(v.name, v.sel, v.a, v.b);
        wait_done(lat);
        check_output({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check_output({v.name, "_res"}, result, v.exp_res);
        check_output({v.name, "_zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
        check_output({v.name, "_ill"}, {31'd0, illegal}, {31'd0, v.exp_ill});
        @(posedge clk); #1;
        check_output({v.name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int  lat;
        bit  seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_sel   = 4'b0000;
        op_a      = '0;
        op_b      = '0;

        #12;
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_result", result, 32'd0);
        check_output("rst_flags", {30'd0, zero, illegal}, 32'd0);
        #5 rst = 1'b0;
        @(posedge clk); #1;
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);

        vecs.push_back(mk("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("sub_neg",  4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sra_31",   4'b0111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 32));
        vecs.push_back(mk("srl_31",   4'b0101, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 32));
        vecs.push_back(mk("sra_0",    4'b0111, 32'h80000000, 32'd0,        32'h80000000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sll_hib",  4'b0100, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, 1'b0, 1'b0, 5));
        vecs.push_back(mk("sra_pos",  4'b0111, 32'h40000000, 32'd3,        32'h08000000, 1'b0, 1'b0, 4));
        vecs.push_back(mk("slt",      4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sltu",     4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("or",       4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("xor",      4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("ill_1111", 4'b1111, 32'd5,        32'd3,        32'h00000000, 1'b1, 1'b1, 1));
        vecs.push_back(mk("add_23a",  4'b0010, 32'd2,        32'd3,        32'h00000005, 1'b0, 1'b0, 1));
        vecs.push_back(mk("ill_1010", 4'b1010, 32'd9,        32'd9,        32'h00000000, 1'b1, 1'b1, 1));
        vecs.push_back(mk("add_23b",  4'b0010, 32'd2,        32'd3,        32'h00000005, 1'b0, 1'b0, 1));

        foreach (vecs[i]) run_vector(vecs[i]);

        // Reset in the middle of a long shift must discard the operation entirely.
        apply_stimulus("rst_shift", 4'b0100, 32'h00000001, 32'd20);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_output("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("mid_rst_result", result, 32'd0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_output("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        check_output("mid_rst_no_stale", {31'd0, seen_valid}, 32'd0);
        check_output("mid_rst_result_hold", result, 32'd0);

        // Back-pressure: result must hold while downstream stalls and new requests are refused.
        out_ready = 1'b0;
        apply_stimulus("bp_xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_done(lat);
        check_output("bp_lat", 32'(lat), 32'd1);
        check_output("bp_res", result, 32'h0FF00FF0);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            alu_sel  = 4'b0010;
            op_a     = 32'd1;
            op_b     = 32'd1;
            @(posedge clk); #1;
            check_output("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check_output("bp_hold_res", result, 32'h0FF00FF0);
            check_output("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        check_output("bp_idle_res", result, 32'h0FF00FF0);
        @(posedge clk); #1;
        check_output("bp_no_accept", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
